// File: rtl/t07_bus_pkg.sv
// Shared bus definitions for the memory handler and the MMIO bus bridge.
// Holds the request codes carried on rwi, the bridge state encoding and a
// small decode helper.
package t07_bus_pkg;

    localparam logic [1:0] RWI_IDLE  = 2'b00;
    localparam logic [1:0] RWI_WRITE = 2'b01;
    localparam logic [1:0] RWI_READ  = 2'b10;
    localparam logic [1:0] RWI_FETCH = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } bridge_state_t;

    // Read and fetch both return data; they share the upper code bit.
    function automatic logic rwi_is_read(input logic [1:0] rwi);
        return rwi[1];
    endfunction

endpackage

// File: rtl/t07_mmio_bus_bridge_if.sv
// Wishbone classic-cycle bus bundle.
//   master: cyc, stb, we, adr, dat_m2s, sel out; ack, dat_s2m in
//   slave : mirror image of master
interface t07_mmio_bus_bridge_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_m2s;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] dat_s2m;

    modport master (
        output cyc, stb, we, adr, dat_m2s, sel,
        input  ack, dat_s2m
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m2s, sel,
        output ack, dat_s2m
    );
endinterface

// File: rtl/t07_bus_watchdog.sv
// Ack watchdog: up-counter with synchronous clear (priority) and count enable.
// expire is high while the count sits at TIMEOUT-1, i.e. during the
// TIMEOUT-th enabled cycle after a clear.
//   clk, rst : clock, async active-high reset
//   clr      : force count to zero
//   en       : advance count by one
//   expire   : count has reached TIMEOUT-1
module t07_bus_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/t07_mmio_bus_bridge.sv
// Bridge from the memory handler's level-held request code to single
// Wishbone classic-cycle transactions, with an ack watchdog.
//   clk, rst  : clock, async active-high reset
//   rwi_i     : request code (idle / write / read / fetch)
//   addr_i    : byte address
//   wdata_i   : store data
//   busy_o    : transaction outstanding; falling edge marks completion
//   rdata_o   : registered read/fetch data, held until the next read ack
//   err_o     : sticky watchdog-timeout flag
//   bus       : Wishbone master port (sel is constant all-bytes)
//
// state | meaning
// IDLE  | no transaction in flight
// REQ   | transaction outstanding on the bus
// HOLD  | completed request held until the handler changes rwi_i
module t07_mmio_bus_bridge
    import t07_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   rwi_i,
    input  logic [31:0]                  addr_i,
    input  logic [31:0]                  wdata_i,
    output logic                         busy_o,
    output logic [31:0]                  rdata_o,
    output logic                         err_o,
    t07_mmio_bus_bridge_if.master        bus
);

    bridge_state_t state_q, state_d;
    logic [1:0]    served_q, served_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          expire;
    logic          in_req;

    assign in_req = (state_q == REQ);

    // served_q remembers the code already serviced so a level-held request
    // is never issued twice; only a change of code or a pass through idle
    // re-arms the bridge.
    always_comb begin
        state_d  = state_q;
        served_d = served_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (rwi_i == RWI_IDLE) begin
                    served_d = RWI_IDLE;
                end else if (rwi_i != served_q) begin
                    adr_d    = addr_i;
                    dat_d    = wdata_i;
                    we_d     = (rwi_i == RWI_WRITE);
                    served_d = rwi_i;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // Ack wins over a coincident watchdog expiry.
                if (bus.ack) begin
                    if (rwi_is_read(served_q)) begin
                        rdata_d = bus.dat_s2m;
                    end
                    state_d = HOLD;
                end else if (expire) begin
                    err_d = 1'b1;
                    if (rwi_is_read(served_q)) begin
                        rdata_d = '0;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rwi_i != served_q) begin
                    state_d = IDLE;
                    if (rwi_i == RWI_IDLE) begin
                        served_d = RWI_IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            served_q <= RWI_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    t07_bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_d != REQ),
        .en     (in_req),
        .expire (expire)
    );

    assign bus.cyc     = in_req;
    assign bus.stb     = in_req;
    assign bus.we      = we_q & in_req;
    assign bus.adr     = adr_q;
    assign bus.dat_m2s = dat_q;
    assign bus.sel     = 4'hF;

    assign busy_o  = in_req;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_t07_mmio_bus_bridge.sv
// Directed bench for t07_mmio_bus_bridge, built with TIMEOUT=5.
module tb_t07_mmio_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rwi_i = 2'b00;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        busy_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    t07_mmio_bus_bridge_if bus ();

    t07_mmio_bus_bridge #(
        .TIMEOUT (5),
        .CNT_W   (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rwi_i   (rwi_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .busy_o  (busy_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.ack     = 1'b0;
        bus.dat_s2m = '0;

        // reset state
        step();
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cyc", bus.cyc, 0);
        chk("rst_stb", bus.stb, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_adr", bus.adr, 0);
        chk("rst_dat", bus.dat_m2s, 0);
        chk("rst_sel", bus.sel, 32'hF);
        rst = 1'b0;

        // fetch, zero-wait ack
        rwi_i = 2'b11; addr_i = 32'h100;
        step();
        chk("f_cyc", bus.cyc, 1);
        chk("f_stb", bus.stb, 1);
        chk("f_busy", busy_o, 1);
        chk("f_adr", bus.adr, 32'h100);
        chk("f_we", bus.we, 0);
        bus.ack = 1'b1; bus.dat_s2m = 32'hDEADC0DE;
        step();
        bus.ack = 1'b0; bus.dat_s2m = '0;
        chk("f_busy_fall", busy_o, 0);
        chk("f_cyc_fall", bus.cyc, 0);
        chk("f_rdata", rdata_o, 32'hDEADC0DE);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("f_no_reissue", bus.cyc, 0);
        end

        // store with 3 wait states
        rwi_i = 2'b01; addr_i = 32'h2000; wdata_i = 32'h0000_00AB;
        step();
        chk("s_idle_gap", bus.cyc, 0);
        step();
        chk("s_cyc1", bus.cyc, 1);
        chk("s_we", bus.we, 1);
        chk("s_sel", bus.sel, 32'hF);
        chk("s_dat", bus.dat_m2s, 32'hAB);
        addr_i = 32'hFFFF_0000; wdata_i = 32'h1111_1111;
        step();
        chk("s_cyc2", bus.cyc, 1);
        step();
        chk("s_cyc3", bus.cyc, 1);
        step();
        chk("s_cyc4", bus.cyc, 1);
        chk("s_adr_stable", bus.adr, 32'h2000);
        chk("s_dat_stable", bus.dat_m2s, 32'hAB);
        bus.ack = 1'b1; bus.dat_s2m = 32'hFFFF_0000;
        step();
        bus.ack = 1'b0;
        chk("s_busy_fall", busy_o, 0);
        chk("s_rdata_kept", rdata_o, 32'hDEADC0DE);
        chk("s_err", err_o, 0);

        // load then fetch back-to-back
        rwi_i = 2'b00;
        step();
        rwi_i = 2'b10; addr_i = 32'h300;
        step();
        chk("l_cyc", bus.cyc, 1);
        chk("l_we", bus.we, 0);
        chk("l_adr", bus.adr, 32'h300);
        bus.ack = 1'b1; bus.dat_s2m = 32'h12345678;
        step();
        bus.ack = 1'b0;
        chk("l_busy_fall", busy_o, 0);
        chk("l_rdata", rdata_o, 32'h12345678);
        rwi_i = 2'b11; addr_i = 32'h304;
        step();
        chk("lf_gap", bus.cyc, 0);
        step();
        chk("lf_cyc", bus.cyc, 1);
        chk("lf_we", bus.we, 0);
        chk("lf_adr", bus.adr, 32'h304);
        bus.ack = 1'b1; bus.dat_s2m = 32'hCAFEF00D;
        step();
        bus.ack = 1'b0;
        chk("lf_rdata", rdata_o, 32'hCAFEF00D);

        // timeout: no ack, cyc exactly TIMEOUT=5 cycles
        rwi_i = 2'b10; addr_i = 32'h400;
        step();
        step();
        chk("t_cyc1", bus.cyc, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t_cyc_hold", bus.cyc, 1);
            chk("t_err_early", err_o, 0);
        end
        step();
        chk("t_cyc_end", bus.cyc, 0);
        chk("t_busy", busy_o, 0);
        chk("t_err", err_o, 1);
        chk("t_rdata_zero", rdata_o, 0);
        rwi_i = 2'b11; addr_i = 32'h500;
        step();
        step();
        chk("t2_cyc", bus.cyc, 1);
        bus.ack = 1'b1; bus.dat_s2m = 32'h77;
        step();
        bus.ack = 1'b0;
        chk("t2_rdata", rdata_o, 32'h77);
        chk("t2_err_sticky", err_o, 1);

        // async reset mid-REQ
        rwi_i = 2'b00;
        step();
        rwi_i = 2'b11; addr_i = 32'h600;
        step();
        chk("r_cyc_pre", bus.cyc, 1);
        #2 rst = 1'b1;
        #1;
        chk("r_cyc_async", bus.cyc, 0);
        chk("r_stb_async", bus.stb, 0);
        chk("r_busy_async", busy_o, 0);
        chk("r_err_clr", err_o, 0);
        chk("r_rdata_clr", rdata_o, 0);
        step();
        rst = 1'b0;
        step();
        chk("r_refetch_cyc", bus.cyc, 1);
        chk("r_refetch_adr", bus.adr, 32'h600);
        bus.ack = 1'b1; bus.dat_s2m = 32'h99;
        step();
        bus.ack = 1'b0;
        chk("r_refetch_rdata", rdata_o, 32'h99);

        // ack coincides with watchdog expiry (5th REQ cycle)
        rwi_i = 2'b00;
        step();
        rwi_i = 2'b10; addr_i = 32'h700;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
        end
        chk("c_cyc5", bus.cyc, 1);
        bus.ack = 1'b1; bus.dat_s2m = 32'h55;
        step();
        bus.dat_s2m = 32'hBAD;
        chk("c_err", err_o, 0);
        chk("c_rdata", rdata_o, 32'h55);
        chk("c_busy", busy_o, 0);
        step();
        bus.ack = 1'b0;
        chk("c_hold_ack_ignored", rdata_o, 32'h55);
        chk("c_hold_cyc", bus.cyc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
